// File: rtl/gray_seq_pkg.sv
// Shared types and helpers for the gray-code sequencer: FSM states, direction
// encoding and the binary-to-gray conversion.
package gray_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Widest counter the helper supports; callers cast the result down to N.
    localparam int GRAY_MAX_W = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_step_reg.sv
// Loadable up/down binary register with its gray encoding registered on the
// same edge, so both outputs always describe the same count.
module gray_step_reg
    import gray_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load_i,
    input  logic [N-1:0] load_val_i,
    input  logic         step_i,
    input  logic         dir_i,
    output logic [N-1:0] bin_o,
    output logic [N-1:0] gray_o
);

    logic [N-1:0] bin_q, bin_d;
    logic [N-1:0] gray_q, gray_d;

    // Arithmetic wraps naturally modulo 2^N at the register width.
    always_comb begin
        bin_d = bin_q;
        if (load_i)
            bin_d = load_val_i;
        else if (step_i)
            bin_d = (dir_i == DIR_DOWN) ? bin_q - N'(1) : bin_q + N'(1);
        gray_d = N'(bin2gray(GRAY_MAX_W'(bin_d)));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
        end
    end

    assign bin_o  = bin_q;
    assign gray_o = gray_q;

endmodule

// File: rtl/gray_seq_ctrl.sv
// Command-driven gray-code sequencer: accepts (start, len, dir) and streams
// len consecutive gray codes on a valid/ready port, then pulses done.
module gray_seq_ctrl
    import gray_seq_pkg::*;
#(
    parameter int N     = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [N-1:0]     cmd_start,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_dir,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_gray,
    output logic [N-1:0]     out_bin,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic             aborted_q, aborted_d;
    logic             load, step;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            dir_q     <= DIR_UP;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            dir_q     <= dir_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        dir_d     = dir_q;
        aborted_d = aborted_q;
        load      = 1'b0;
        step      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    load      = 1'b1;
                    rem_d     = cmd_len;
                    dir_d     = cmd_dir;
                    aborted_d = 1'b0;
                    state_d   = (cmd_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (out_ready) begin
                    step  = 1'b1;
                    rem_d = rem_q - LEN_W'(1);
                end
                // A beat coinciding with abort still advances the count.
                if (abort) begin
                    state_d   = ST_DONE;
                    aborted_d = 1'b1;
                end else if (out_ready && rem_q == LEN_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    gray_step_reg #(.N(N)) u_step (
        .clk        (clk),
        .rstn       (rstn),
        .load_i     (load),
        .load_val_i (cmd_start),
        .step_i     (step),
        .dir_i      (dir_q),
        .bin_o      (out_bin),
        .gray_o     (out_gray)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_RUN);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign aborted   = aborted_q;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Scoreboard bench for gray_seq_ctrl (N=4, LEN_W=8) with directed commands.
module tb_gray_seq_ctrl;

    logic       clk = 1'b0;
    logic       rstn, cmd_valid, cmd_ready, cmd_dir, abort;
    logic [3:0] cmd_start, out_gray, out_bin;
    logic [7:0] cmd_len;
    logic       out_valid, out_ready, busy, done, aborted;

    gray_seq_ctrl #(.N(4), .LEN_W(8)) dut (
        .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_start(cmd_start), .cmd_len(cmd_len), .cmd_dir(cmd_dir), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .out_gray(out_gray),
        .out_bin(out_bin), .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] g; logic [3:0] b; } beat_t;
    beat_t exp_q[$];
    int checks = 0, errors = 0, done_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] g, input logic [3:0] b);
        beat_t e;
        e.g = g; e.b = b;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted beat is compared against the scoreboard head.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_gray", int'(out_gray), int'(e.g));
                    chk("beat_bin", int'(out_bin), int'(e.b));
                end
            end
        end
    end

    task automatic send_cmd(input logic [3:0] st, input logic [7:0] len, input logic dir);
        int n;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_start = st; cmd_len = len; cmd_dir = dir;
        n = 0;
        do begin @(negedge clk); n++; end while (cmd_ready !== 1'b1 && n < 50);
        if (cmd_ready !== 1'b1) chk("cmd_accept_timeout", 0, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Waits for the done pulse; exp_cyc>0 also checks negedges counted to it.
    task automatic wait_done(input logic exp_ab, input int exp_cyc);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (done !== 1'b1 && n < 100);
        if (done !== 1'b1) begin
            chk("done_timeout", 0, 1);
        end else begin
            chk("aborted_at_done", int'(aborted), int'(exp_ab));
            chk("beats_left_at_done", exp_q.size(), 0);
            if (exp_cyc > 0) chk("cycles_to_done", n, exp_cyc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0; cmd_valid = 1'b0; cmd_start = '0; cmd_len = '0; cmd_dir = 1'b0;
        abort = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_aborted", int'(aborted), 0);
        chk("rst_out_gray", int'(out_gray), 0);

        // 1: 0..3 up, consecutive beats, done, then ready again
        push(0, 0); push(1, 1); push(3, 2); push(2, 3);
        send_cmd(4'd0, 8'd4, 1'b0);
        wait_done(1'b0, 5);
        @(negedge clk);
        chk("t1_cmd_ready_after", int'(cmd_ready), 1);
        chk("t1_next_bin", int'(out_bin), 4);
        chk("t1_next_gray", int'(out_gray), 6);

        // 2: up across the 15->0 wrap
        push(9, 14); push(8, 15); push(0, 0); push(1, 1);
        send_cmd(4'd14, 8'd4, 1'b0);
        wait_done(1'b0, 5);

        // 3: down across the 0->15 wrap
        push(1, 1); push(0, 0); push(8, 15);
        send_cmd(4'd1, 8'd3, 1'b1);
        wait_done(1'b0, 4);

        // 4: backpressure holds the first code stable
        out_ready = 1'b0;
        push(3, 2); push(2, 3); push(6, 4);
        send_cmd(4'd2, 8'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", int'(out_valid), 1);
            chk("t4_hold_gray", int'(out_gray), 3);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_done(1'b0, 4);

        // 5a: zero-length run emits nothing
        send_cmd(4'd7, 8'd0, 1'b0);
        wait_done(1'b0, 1);
        chk("t5_len0_bin_loaded", int'(out_bin), 7);

        // 5b: abort on beat 2 of 8; that beat still counts
        push(0, 0); push(1, 1);
        send_cmd(4'd0, 8'd8, 1'b0);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_done(1'b1, 0);
        @(negedge clk);
        chk("t5_aborted_held", int'(aborted), 1);
        chk("t5_bin_after_abort", int'(out_bin), 2);
        chk("t5_gray_after_abort", int'(out_gray), 3);

        // 6: reset during beat 3 of 8 kills the run without a done pulse
        push(0, 0); push(1, 1); push(3, 2);
        send_cmd(4'd0, 8'd8, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("t6_valid_after_rst", int'(out_valid), 0);
        chk("t6_busy_after_rst", int'(busy), 0);
        chk("t6_gray_after_rst", int'(out_gray), 0);
        chk("t6_bin_after_rst", int'(out_bin), 0);
        chk("t6_done_after_rst", int'(done), 0);
        chk("t6_aborted_after_rst", int'(aborted), 0);
        chk("t6_cmd_ready_after_rst", int'(cmd_ready), 1);

        // fresh command after the kill runs normally
        push(7, 5); push(6, 4);
        send_cmd(4'd5, 8'd2, 1'b1);
        wait_done(1'b0, 3);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("total_done_pulses", done_cnt, 7);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
